// File: rtl/hb_prio_task_queue_pkg.sv
// hb_tq_pkg: shared widths, pop-select result type and priority encoder for the task queue
package hb_tq_pkg;
    function automatic int w1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int DEPTH_D     = 16;
    localparam int NUM_PRIO_D  = 4;
    localparam int PTR_W       = w1(DEPTH_D);
    localparam int CNT_W       = w1(DEPTH_D + 1);
    localparam int PRIO_W      = w1(NUM_PRIO_D);
    localparam int MAX_CLASSES = 32;
    localparam int SEL_W       = 5;
    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] prio;
    } sel_t;
    // Scanning from the top down lets the lowest set index win.
    function automatic sel_t lowest_set(input logic [MAX_CLASSES-1:0] m);
        sel_t s;
        s = '0;
        for (int i = MAX_CLASSES - 1; i >= 0; i--)
            if (m[i]) begin
                s.valid = 1'b1;
                s.prio  = SEL_W'(i);
            end
        return s;
    endfunction
endpackage

// File: rtl/hb_prio_task_queue_if.sv
// hb_tq_if: push/pop/flush/status bundle of the priority task queue
//   master: host/worker side (drives push_*, data_in, pop_req, flush)
//   slave:  queue side (drives push_ready, full, almost_full, valid_out, data_out, prio_out, total_count)
interface hb_tq_if #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 32,
    parameter int NUM_PRIO = 4
);
    localparam int PW = hb_tq_pkg::w1(NUM_PRIO);
    localparam int TW = $clog2(NUM_PRIO * DEPTH + 1);
    logic                push_req;
    logic [PW-1:0]       push_prio;
    logic [WIDTH-1:0]    data_in;
    logic                push_ready;
    logic [NUM_PRIO-1:0] full;
    logic [NUM_PRIO-1:0] almost_full;
    logic                valid_out;
    logic [WIDTH-1:0]    data_out;
    logic [PW-1:0]       prio_out;
    logic                pop_req;
    logic                flush;
    logic [TW-1:0]       total_count;
    modport master (
        output push_req, push_prio, data_in, pop_req, flush,
        input  push_ready, full, almost_full, valid_out, data_out, prio_out, total_count
    );
    modport slave (
        input  push_req, push_prio, data_in, pop_req, flush,
        output push_ready, full, almost_full, valid_out, data_out, prio_out, total_count
    );
endinterface

// File: rtl/hb_prio_task_queue_ring.sv
// hb_tq_ring: one priority class as a first-word-fall-through ring FIFO
//   in:  clk, reset, flush, push (already qualified by !full), pop (already qualified), data_in
//   out: full, almost_full, empty, head_data, count
module hb_tq_ring #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 32,
    parameter int AF_THRESH = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               data_in,
    output logic                           full,
    output logic                           almost_full,
    output logic                           empty,
    output logic [WIDTH-1:0]               head_data,
    output logic [$clog2(DEPTH + 1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head, tail;
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // Storage is never cleared; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) mem[tail] <= data_in;
    end
    assign full        = count == CW'(DEPTH);
    assign almost_full = count >= CW'(AF_THRESH);
    assign empty       = count == '0;
    assign head_data   = mem[head];
endmodule

// File: rtl/hb_prio_task_queue.sv
// hb_prio_task_queue: NUM_PRIO ring FIFOs behind one strict-priority pop port with starvation guard
//   clk, reset: clock and synchronous active-high reset
//   bus (hb_tq_if.slave): push/pop handshake, flush, per-class full/almost_full, total_count
module hb_prio_task_queue
    import hb_tq_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int WIDTH        = 32,
    parameter int NUM_PRIO     = 4,
    parameter int AF_THRESH    = 12,
    parameter int STARVE_LIMIT = 8
) (
    input logic   clk,
    input logic   reset,
    hb_tq_if.slave bus
);
    localparam int PW = w1(NUM_PRIO);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = w1(STARVE_LIMIT + 1);
    localparam int TW = $clog2(NUM_PRIO * DEPTH + 1);
    logic [NUM_PRIO-1:0]    full_v, af_v, empty_v, push_v, pop_v;
    logic [WIDTH-1:0]       head_v [NUM_PRIO];
    logic [CW-1:0]          cnt_v  [NUM_PRIO];
    logic [SW-1:0]          starve [NUM_PRIO];
    logic [MAX_CLASSES-1:0] ne_m, st_m;
    logic [TW-1:0]          total;
    logic [PW-1:0]          sel_prio;
    logic                   push_ok, pop_ok;
    sel_t                   sel;
    // A starved, non-empty class pre-empts the plain strict-priority choice.
    always_comb begin
        ne_m = '0;
        st_m = '0;
        for (int i = 0; i < NUM_PRIO; i++) begin
            ne_m[i] = !empty_v[i];
            st_m[i] = (STARVE_LIMIT != 0) && !empty_v[i] && (starve[i] >= SW'(STARVE_LIMIT));
        end
        sel = |st_m ? lowest_set(st_m) : lowest_set(ne_m);
    end
    assign sel_prio        = sel.prio[PW-1:0];
    assign bus.push_ready  = (int'(bus.push_prio) < NUM_PRIO) && !full_v[bus.push_prio];
    assign push_ok         = bus.push_req && bus.push_ready;
    assign pop_ok          = bus.pop_req && sel.valid;
    assign bus.valid_out   = sel.valid;
    assign bus.prio_out    = sel_prio;
    assign bus.data_out    = head_v[sel_prio];
    assign bus.full        = full_v;
    assign bus.almost_full = af_v;
    assign bus.total_count = total;
    for (genvar g = 0; g < NUM_PRIO; g++) begin : g_ring
        assign push_v[g] = push_ok && (bus.push_prio == PW'(g));
        assign pop_v[g]  = pop_ok && (sel_prio == PW'(g));
        hb_tq_ring #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_THRESH(AF_THRESH)) u_ring (
            .clk(clk), .reset(reset), .flush(bus.flush), .push(push_v[g]), .pop(pop_v[g]),
            .data_in(bus.data_in), .full(full_v[g]), .almost_full(af_v[g]), .empty(empty_v[g]),
            .head_data(head_v[g]), .count(cnt_v[g])
        );
    end
    // Only the served class can drain, so clearing it also covers "becomes empty".
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            total <= '0;
            for (int i = 0; i < NUM_PRIO; i++) starve[i] <= '0;
        end else begin
            total <= total + TW'(push_ok) - TW'(pop_ok);
            if (pop_ok)
                for (int i = 0; i < NUM_PRIO; i++)
                    starve[i] <= (i == int'(sel_prio)) ? '0 :
                                 (i > int'(sel_prio) && !empty_v[i] && starve[i] != SW'(STARVE_LIMIT)) ?
                                 starve[i] + 1'b1 : starve[i];
        end
    end
endmodule

// File: tb/tb_hb_prio_task_queue.sv
// tb_hb_prio_task_queue: directed self-checking bench for hb_prio_task_queue
module tb_hb_prio_task_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    hb_tq_if #(.DEPTH(16), .WIDTH(32), .NUM_PRIO(4)) bus ();
    hb_prio_task_queue #(.DEPTH(16), .WIDTH(32), .NUM_PRIO(4), .AF_THRESH(12), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic push(input int c, input logic [31:0] d);
        bus.push_req = 1'b1;
        bus.push_prio = 2'(c);
        bus.data_in = d;
        tick();
        bus.push_req = 1'b0;
    endtask
    task automatic pop();
        bus.pop_req = 1'b1;
        tick();
        bus.pop_req = 1'b0;
    endtask
    initial begin
        bus.push_req = 1'b0;
        bus.push_prio = '0;
        bus.data_in = '0;
        bus.pop_req = 1'b0;
        bus.flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", 32'(bus.valid_out), 0);
        chk("rst_total", 32'(bus.total_count), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_af", 32'(bus.almost_full), 0);
        chk("rst_ready", 32'(bus.push_ready), 1);
        chk("rst_prio", 32'(bus.prio_out), 0);
        push(2, 32'hA0);
        push(0, 32'hB0);
        chk("t1_valid", 32'(bus.valid_out), 1);
        chk("t1_prio0", 32'(bus.prio_out), 0);
        chk("t1_data0", bus.data_out, 32'hB0);
        chk("t1_total", 32'(bus.total_count), 2);
        pop();
        chk("t1_prio2", 32'(bus.prio_out), 2);
        chk("t1_data2", bus.data_out, 32'hA0);
        pop();
        chk("t1_empty", 32'(bus.valid_out), 0);
        chk("t1_total0", 32'(bus.total_count), 0);
        for (int i = 0; i < 16; i++) begin
            push(1, 32'(i));
            chk("t2_af", 32'(bus.almost_full[1]), (i >= 11) ? 1 : 0);
            chk("t2_full", 32'(bus.full[1]), (i == 15) ? 1 : 0);
        end
        bus.push_prio = 2'd1;
        #1;
        chk("t2_ready", 32'(bus.push_ready), 0);
        push(1, 32'h99);
        chk("t2_drop_total", 32'(bus.total_count), 16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_order", bus.data_out, 32'(i));
            pop();
        end
        chk("t2_drained", 32'(bus.valid_out), 0);
        for (int i = 0; i < 4; i++) begin
            push(1, 32'h50 + 32'(i));
            chk("t2_wrap", bus.data_out, 32'h50 + 32'(i));
            pop();
        end
        for (int i = 0; i < 16; i++) push(1, 32'h10 + 32'(i));
        bus.push_req = 1'b1;
        bus.push_prio = 2'd1;
        bus.data_in = 32'hEE;
        bus.pop_req = 1'b1;
        tick();
        bus.push_req = 1'b0;
        bus.pop_req = 1'b0;
        chk("t3_count", 32'(bus.total_count), 15);
        for (int i = 1; i < 16; i++) begin
            chk("t3_order", bus.data_out, 32'h10 + 32'(i));
            pop();
        end
        chk("t3_empty", 32'(bus.valid_out), 0);
        for (int i = 0; i < 5; i++) push(1, 32'h40 + 32'(i));
        bus.push_req = 1'b1;
        bus.push_prio = 2'd1;
        bus.data_in = 32'h45;
        bus.pop_req = 1'b1;
        tick();
        bus.push_req = 1'b0;
        bus.pop_req = 1'b0;
        chk("t4_count", 32'(bus.total_count), 5);
        for (int i = 1; i < 6; i++) begin
            chk("t4_order", bus.data_out, 32'h40 + 32'(i));
            pop();
        end
        chk("t4_empty", 32'(bus.total_count), 0);
        push(3, 32'h33);
        push(0, 32'h00);
        for (int k = 1; k <= 8; k++) begin
            chk("t5_serve0", 32'(bus.prio_out), 0);
            bus.pop_req = 1'b1;
            push(0, 32'(k));
            bus.pop_req = 1'b0;
        end
        chk("t5_forced_prio", 32'(bus.prio_out), 3);
        chk("t5_forced_data", bus.data_out, 32'h33);
        pop();
        chk("t5_back_prio", 32'(bus.prio_out), 0);
        chk("t5_back_data", bus.data_out, 32'h08);
        chk("t5_total", 32'(bus.total_count), 1);
        pop();
        chk("t5_empty", 32'(bus.valid_out), 0);
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 3; i++) push(c, 32'(c * 16 + i));
        chk("t6_total12", 32'(bus.total_count), 12);
        chk("t6_head", bus.data_out, 32'h00);
        bus.flush = 1'b1;
        bus.push_req = 1'b1;
        bus.push_prio = 2'd0;
        bus.pop_req = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.push_req = 1'b0;
        bus.pop_req = 1'b0;
        chk("t6_fl_valid", 32'(bus.valid_out), 0);
        chk("t6_fl_total", 32'(bus.total_count), 0);
        chk("t6_fl_full", 32'(bus.full), 0);
        chk("t6_fl_af", 32'(bus.almost_full), 0);
        push(2, 32'h77);
        push(1, 32'h66);
        chk("t6_refill", 32'(bus.total_count), 2);
        chk("t6_refill_prio", 32'(bus.prio_out), 1);
        reset = 1'b1;
        bus.push_req = 1'b1;
        bus.push_prio = 2'd3;
        bus.pop_req = 1'b1;
        tick();
        reset = 1'b0;
        bus.push_req = 1'b0;
        bus.pop_req = 1'b0;
        chk("t6_rs_valid", 32'(bus.valid_out), 0);
        chk("t6_rs_total", 32'(bus.total_count), 0);
        chk("t6_rs_ready", 32'(bus.push_ready), 1);
        chk("t6_rs_prio", 32'(bus.prio_out), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
